bcd_display_seq: RTL and testbench

Sequential signed-binary-to-7-segment display controller for picoMIPS. Watches the CPU `display` bus. Whenever the value changes, it runs a multi-cycle shift-add-3 (double-dabble) conversion and drives four registered 7-segment outputs: sign, hundreds, tens and units. It sits between `cpu` and the board pins, on the same clock as the CPU, and replaces the purely combinational display decoder with a sequenced, glitch-free one.

---
 rtl/display_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 26 ++
 rtl/bcd_display_seq.sv | 137 +++++++++++++
 tb/tb_bcd_display_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the sequenced BCD display controller.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } disp_state_t;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low 7-segment pattern (gfedcba). Non-decimal codes blank.
module seg7_decode (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    import display_pkg::*;

    // Pure lookup; nibbles 10..15 cannot come out of the converter but stay dark
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_seq.sv
// Sequenced signed-binary to 3-digit 7-segment display controller.
// Each change of `display` runs an n-cycle shift-add-3 conversion; the
// segment outputs are registered and only ever change at the DONE edge.
//
// state | meaning
// IDLE  | waiting; starts a conversion when display differs from last shown value
// SHIFT | one double-dabble step per cycle, bit counter runs down from n to 1
// DONE  | latch segment patterns and sign, pulse done, mark result valid
module bcd_display_seq
    import display_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] display,
    output logic [6:0]   digits,
    output logic [6:0]   ten_digits,
    output logic [6:0]   hun_digits,
    output logic [6:0]   sign,
    output logic         busy,
    output logic         done
);

    localparam int CNT_W = $clog2(n + 1);

    disp_state_t      state;
    disp_state_t      state_nxt;
    logic             start;

    logic [n-1:0]     mag_q;
    logic [BCD_W-1:0] bcd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q;
    logic             valid_q;
    logic [n-1:0]     last_q;

    logic [n-1:0]     mag_in;
    logic [BCD_W-1:0] bcd_adj;
    logic [6:0]       seg_units;
    logic [6:0]       seg_tens;
    logic [6:0]       seg_huns;

    // Unsigned magnitude of the incoming value; -2^(n-1) wraps to 2^(n-1) as intended
    always_comb begin
        mag_in = display;
        if (display[n-1]) begin
            mag_in = ~display + {{(n-1){1'b0}}, 1'b1};
        end
    end

    always_comb bcd_adj = bcd_adjust(bcd_q);

    seg7_decode u_seg_units (.bcd(bcd_q[3:0]),  .seg(seg_units));
    seg7_decode u_seg_tens  (.bcd(bcd_q[7:4]),  .seg(seg_tens));
    seg7_decode u_seg_huns  (.bcd(bcd_q[11:8]), .seg(seg_huns));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a stale or never-shown value restarts the converter
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (!valid_q || (display != last_q)) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Conversion datapath and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= '0;
            digits     <= SEG_ZERO;
            ten_digits <= SEG_ZERO;
            hun_digits <= SEG_ZERO;
            sign       <= SEG_BLANK;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg_q  <= display[n-1];
                        mag_q  <= mag_in;
                        bcd_q  <= '0;
                        cnt_q  <= CNT_W'(n);
                        last_q <= display;
                    end
                end
                SHIFT: begin
                    {bcd_q, mag_q} <= {bcd_adj[BCD_W-2:0], mag_q, 1'b0};
                    cnt_q          <= cnt_q - CNT_W'(1);
                end
                DONE: begin
                    digits     <= seg_units;
                    ten_digits <= seg_tens;
                    hun_digits <= seg_huns;
                    sign       <= neg_q ? SEG_MINUS : SEG_BLANK;
                    valid_q    <= 1'b1;
                    done       <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_seq.sv
module tb_bcd_display_seq;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_MINUS = 7'b0111111;
    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D8 = 7'b0000000;
    localparam logic [6:0] D9 = 7'b0010000;

    logic       clk;
    logic       reset;
    logic [7:0] display;
    logic [6:0] digits, ten_digits, hun_digits, sign;
    logic       busy, done;

    int total = 0;
    int bad   = 0;

    // expected {sign, hun, ten, units}
    logic [27:0] exp_q[$];

    bcd_display_seq #(.n(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .display    (display),
        .digits     (digits),
        .ten_digits (ten_digits),
        .hun_digits (hun_digits),
        .sign       (sign),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk7(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [6:0] s, input logic [6:0] h, input logic [6:0] t, input logic [6:0] u);
        exp_q.push_back({s, h, t, u});
    endtask

    // Monitor: scoreboard compare on every done pulse, stability check otherwise
    logic [27:0] prev_out;
    logic        prev_done = 1'b0;
    always @(posedge clk) begin
        logic [27:0] cur;
        logic [27:0] e;
        #1;
        cur = {sign, hun_digits, ten_digits, digits};
        if (!reset) begin
            if (done) begin
                chk_int("done_width", int'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got output %h expected no conversion at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk7("sign", sign, e[27:21]);
                    chk7("hun_digits", hun_digits, e[20:14]);
                    chk7("ten_digits", ten_digits, e[13:7]);
                    chk7("digits", digits, e[6:0]);
                end
            end else begin
                total++;
                if (cur !== prev_out) begin
                    bad++;
                    $display("FAIL stability: got %h expected %h at %0t", cur, prev_out, $time);
                end
            end
        end
        prev_out  = cur;
        prev_done = done;
    end

    // Count edges from a stimulus change until done is seen
    task automatic measure(output int k);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) chk_int("busy_after_sample", int'(busy), 1);
            if (done) begin
                chk_int("busy_at_done", int'(busy), 0);
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL measure_timeout: got no done expected done within 40 edges");
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) return;
        end
        total++;
        bad++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        reset   = 1'b1;
        display = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk7("rst_digits", digits, D0);
        chk7("rst_ten", ten_digits, D0);
        chk7("rst_hun", hun_digits, D0);
        chk7("rst_sign", sign, S_BLANK);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_done", int'(done), 0);

        // Release with display=0: conversion anyway since nothing is valid yet
        @(negedge clk);
        reset = 1'b0;
        push(S_BLANK, D0, D0, D0);
        measure(lat);
        chk_int("latency_reset_release", lat, 10);

        // 127
        @(negedge clk);
        display = 8'd127;
        push(S_BLANK, D1, D2, D7);
        measure(lat);
        chk_int("latency_127", lat, 10);
        @(posedge clk);
        #1;
        chk_int("done_drop", int'(done), 0);

        // -128
        @(negedge clk);
        display = 8'h80;
        push(S_MINUS, D1, D2, D8);
        drain(40);

        // -1
        @(negedge clk);
        display = 8'hFF;
        push(S_MINUS, D0, D0, D1);
        drain(40);

        // 5 then 42 arriving during the third SHIFT cycle
        @(negedge clk);
        display = 8'd5;
        push(S_BLANK, D0, D0, D5);
        push(S_BLANK, D0, D4, D2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        display = 8'd42;
        drain(60);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk_int("no_third_busy", int'(busy), 0);
        end

        // 99 aborted by reset in the fourth SHIFT cycle
        @(negedge clk);
        display = 8'd99;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk7("abort_digits", digits, D0);
        chk7("abort_ten", ten_digits, D0);
        chk7("abort_hun", hun_digits, D0);
        chk7("abort_sign", sign, S_BLANK);
        chk_int("abort_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        push(S_BLANK, D0, D9, D9);
        drain(40);

        // Hold constant: no further activity
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            chk_int("hold_busy", int'(busy), 0);
            chk_int("hold_done", int'(done), 0);
        end
        chk7("hold_digits", digits, D9);
        chk7("hold_ten", ten_digits, D9);
        chk_int("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
